// File: rtl/fft32_out_reorder.sv
// Reorders bit-reversed FFT output frames into natural bin order via a ping-pong buffer.
// Latency: bin 0 leaves 2 edges after the last sample of a frame; no input backpressure.
module fft32_out_reorder #(
    parameter int DW   = 18,
    parameter int N    = 32,
    parameter int LOGN = 5
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   valid_i,
    input  logic signed [DW-1:0]   data_in_r,
    input  logic signed [DW-1:0]   data_in_i,
    output logic                   valid_o,
    output logic signed [DW-1:0]   data_out_r,
    output logic signed [DW-1:0]   data_out_i,
    output logic [LOGN-1:0]        bin_o,
    output logic                   sof_o
);

    typedef enum logic {S_IDLE, S_READ} state_t;

    function automatic logic [LOGN-1:0] bitrev(input logic [LOGN-1:0] a);
        logic [LOGN-1:0] b;
        for (int j = 0; j < LOGN; j++) b[j] = a[LOGN-1-j];
        return b;
    endfunction

    logic [2*DW-1:0] r_mem [2][N];

    logic [LOGN-1:0] r_wcnt;
    logic            r_wbank;
    logic [1:0]      r_full;
    logic            r_rbank;
    logic [LOGN-1:0] r_raddr;
    state_t          r_state;

    logic            r_valid;
    logic [DW-1:0]   r_dat_r;
    logic [DW-1:0]   r_dat_i;
    logic [LOGN-1:0] r_bin;
    logic            r_sof;

    state_t          w_state_nxt;
    logic [LOGN-1:0] w_raddr_nxt;
    logic            w_rbank_nxt;
    logic            w_rd_done;
    logic            w_wr_done;
    logic [LOGN-1:0] w_waddr;

    assign w_waddr   = bitrev(r_wcnt);
    assign w_wr_done = valid_i && (r_wcnt == LOGN'(N-1));

    // Buffer contents survive reset; only the bookkeeping is cleared.
    always_ff @(posedge clk) begin
        if (valid_i) r_mem[r_wbank][w_waddr] <= {data_in_r, data_in_i};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wcnt  <= '0;
            r_wbank <= 1'b0;
        end else if (valid_i) begin
            r_wcnt <= r_wcnt + 1'b1;
            if (w_wr_done) r_wbank <= ~r_wbank;
        end
    end

    // Set and clear never hit the same bank in one cycle: a full bank is never written.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_full <= '0;
        end else begin
            for (int b = 0; b < 2; b++) begin
                r_full[b] <= (r_full[b] | (w_wr_done && (r_wbank == 1'(b))))
                           & ~(w_rd_done && (r_rbank == 1'(b)));
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_raddr <= '0;
            r_rbank <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_raddr <= w_raddr_nxt;
            r_rbank <= w_rbank_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_raddr_nxt = r_raddr;
        w_rbank_nxt = r_rbank;
        w_rd_done   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (r_full[r_rbank]) begin
                    w_state_nxt = S_READ;
                    w_raddr_nxt = '0;
                end
            end
            S_READ: begin
                w_raddr_nxt = r_raddr + 1'b1;
                if (r_raddr == LOGN'(N-1)) begin
                    w_rd_done   = 1'b1;
                    w_rbank_nxt = ~r_rbank;
                    w_state_nxt = r_full[~r_rbank] ? S_READ : S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst || (r_state != S_READ)) begin
            r_valid <= 1'b0;
            r_dat_r <= '0;
            r_dat_i <= '0;
            r_bin   <= '0;
            r_sof   <= 1'b0;
        end else begin
            r_valid <= 1'b1;
            {r_dat_r, r_dat_i} <= r_mem[r_rbank][r_raddr];
            r_bin   <= r_raddr;
            r_sof   <= (r_raddr == '0);
        end
    end

    assign valid_o    = r_valid;
    assign data_out_r = r_dat_r;
    assign data_out_i = r_dat_i;
    assign bin_o      = r_bin;
    assign sof_o      = r_sof;

endmodule

// File: tb/tb_fft32_out_reorder.sv
// Bench for fft32_out_reorder: random and directed frames against a frame-level output schedule.
module tb_fft32_out_reorder;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               valid_i = 1'b0;
    logic signed [17:0] data_in_r = '0;
    logic signed [17:0] data_in_i = '0;
    logic               valid_o;
    logic signed [17:0] data_out_r;
    logic signed [17:0] data_out_i;
    logic [4:0]         bin_o;
    logic               sof_o;

    fft32_out_reorder #(.DW(18), .N(32), .LOGN(5)) dut (
        .clk(clk), .rst(rst), .valid_i(valid_i),
        .data_in_r(data_in_r), .data_in_i(data_in_i),
        .valid_o(valid_o), .data_out_r(data_out_r), .data_out_i(data_out_i),
        .bin_o(bin_o), .sof_o(sof_o)
    );

    always #5 clk = ~clk;

    typedef struct { int r; int i; int bin; } exp_t;

    exp_t exp_q [int];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   cyc = 0;
    bit   armed = 0;
    int   k = 0;
    int   fr_r [32];
    int   fr_i [32];
    int   done_edge = -1;
    int   sof_edge = -1;
    int   run = 0;
    int   max_run = 0;
    int   cap_r [32];
    int   cap_i [32];

    function automatic int brev(input int a);
        int b = 0;
        for (int j = 0; j < 5; j++) b += ((a >> j) & 1) << (4 - j);
        return b;
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    // Compare DUT outputs of the last edge, then fold the inputs of the coming edge into the model.
    always @(negedge clk) begin
        if (armed) begin
            bit ev;
            int er, ei, eb;
            bit esof;
            ev = exp_q.exists(cyc);
            er = ev ? exp_q[cyc].r : 0;
            ei = ev ? exp_q[cyc].i : 0;
            eb = ev ? exp_q[cyc].bin : 0;
            esof = ev && (eb == 0);
            n_cmp++;
            if (valid_o !== ev || int'(data_out_r) != er || int'(data_out_i) != ei ||
                int'(bin_o) != eb || sof_o !== esof || $isunknown({data_out_r, data_out_i, bin_o})) begin
                n_bad++;
                $display("FAIL out@%0d: got vld=%0b r=%0d i=%0d bin=%0d sof=%0b, want vld=%0b r=%0d i=%0d bin=%0d sof=%0b",
                         cyc, valid_o, data_out_r, data_out_i, bin_o, sof_o, ev, er, ei, eb, esof);
            end
            if (ev) exp_q.delete(cyc);
            if (valid_o === 1'b1) begin
                cap_r[bin_o] = int'(data_out_r);
                cap_i[bin_o] = int'(data_out_i);
                run++;
                if (run > max_run) max_run = run;
            end else begin
                run = 0;
            end
            if (sof_o === 1'b1) sof_edge = cyc;
        end
        if (rst) begin
            exp_q.delete();
            k = 0;
            armed = 1;
        end else if (armed && valid_i) begin
            n_cmp++;
            if (dut.r_full[dut.r_wbank] && !(dut.w_rd_done && dut.r_rbank == dut.r_wbank)) begin
                n_bad++;
                $display("FAIL wr_into_full@%0d: bank=%0d full=%b, want bank not full", cyc, dut.r_wbank, dut.r_full);
            end
            fr_r[brev(k)] = int'(data_in_r);
            fr_i[brev(k)] = int'(data_in_i);
            k++;
            if (k == 32) begin
                done_edge = cyc + 1;
                for (int n = 0; n < 32; n++) begin
                    exp_t e;
                    e.r = fr_r[n]; e.i = fr_i[n]; e.bin = n;
                    exp_q[done_edge + 2 + n] = e;
                end
                k = 0;
            end
        end
    end

    task automatic check(input string name, input int got, input int want);
        n_cmp++;
        if (got != want) begin
            n_bad++;
            $display("FAIL %s: got %0d, want %0d", name, got, want);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input int r, input int i, input int gap);
        valid_i = 1'b0;
        repeat (gap) tick();
        valid_i = 1'b1;
        data_in_r = 18'(r);
        data_in_i = 18'(i);
        tick();
        valid_i = 1'b0;
    endtask

    task automatic idle(input int n);
        valid_i = 1'b0;
        repeat (n) tick();
    endtask

    task automatic pulse_rst();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic clr_cap();
        for (int n = 0; n < 32; n++) begin
            cap_r[n] = 12345;
            cap_i[n] = 12345;
        end
        sof_edge = -1;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + 1);
        $fatal(1);
    end

    initial begin
        tick();
        tick();
        rst = 1'b0;
        check("reset_valid", int'(valid_o), 0);
        check("reset_bin", int'(bin_o), 0);

        // Single frame r=k, i=-k
        clr_cap();
        for (int j = 0; j < 32; j++) send(j, -j, 0);
        idle(40);
        check("s1_bin1_r", cap_r[1], 16);
        check("s1_bin1_i", cap_i[1], -16);
        check("s1_bin2_r", cap_r[2], 8);
        check("s1_bin3_r", cap_r[3], 24);
        check("s1_bin31_i", cap_i[31], -31);
        check("s1_latency", sof_edge - done_edge, 2);

        // Three back-to-back frames
        clr_cap();
        max_run = 0;
        for (int f = 0; f < 3; f++)
            for (int j = 0; j < 32; j++) send(100 * f + j, -(100 * f + j), 0);
        idle(40);
        check("s2_run_len", max_run, 96);
        check("s2_f2_bin1", cap_r[1], 216);

        // Gapped input 1,0,0,1,...
        clr_cap();
        max_run = 0;
        for (int j = 0; j < 32; j++) send(j, -j, (j == 0) ? 0 : 2);
        idle(40);
        check("s3_bin3_r", cap_r[3], 24);
        check("s3_latency", sof_edge - done_edge, 2);
        check("s3_run_len", max_run, 32);

        // Full-scale extremes
        clr_cap();
        for (int j = 0; j < 32; j++)
            send((j % 2 == 0) ? 131071 : -131072, (j % 2 == 0) ? -131072 : 131071, 0);
        idle(40);
        check("s4_bin0_r", cap_r[0], 131071);
        check("s4_bin0_i", cap_i[0], -131072);
        check("s4_bin16_r", cap_r[16], -131072);
        check("s4_bin31_i", cap_i[31], 131071);

        // Reset mid-frame
        clr_cap();
        for (int j = 0; j < 20; j++) send(900 + j, 900 + j, 0);
        pulse_rst();
        for (int j = 0; j < 32; j++) send(500 + j, -(500 + j), 0);
        idle(40);
        check("s5_bin1_r", cap_r[1], 516);
        check("s5_bin5_i", cap_i[5], -(500 + 20));

        // Reset during readout
        for (int j = 0; j < 32; j++) send(300 + j, 300 + j, 0);
        begin
            bit found = 0;
            for (int t = 0; t < 100 && !found; t++) begin
                if (valid_o === 1'b1 && bin_o == 5'd10) found = 1;
                else tick();
            end
            check("s6_reach_bin10", int'(found), 1);
        end
        pulse_rst();
        check("s6_rst_valid", int'(valid_o), 0);
        check("s6_rst_data", int'(data_out_r), 0);
        check("s6_rst_bin", int'(bin_o), 0);
        clr_cap();
        for (int j = 0; j < 32; j++) send(700 + j, -(700 + j), 0);
        idle(40);
        check("s6_bin2_r", cap_r[2], 708);
        check("s6_latency", sof_edge - done_edge, 2);

        // Random values with random gaps
        for (int f = 0; f < 12; f++) begin
            for (int j = 0; j < 32; j++) begin
                int gap;
                gap = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0;
                send(int'(18'($urandom)) - ((($urandom & 32'h20000) != 0) ? 0 : 0),
                     int'($signed(18'($urandom))), (f % 4 == 0) ? 0 : gap);
            end
        end
        idle(80);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
